i_fill_ctrl: RTL

// - Instruction-cache refill engine, directly upstream of the i-cache write port.
// - On an i-cache miss it fetches the 16-word line containing the missing PC from instruction memory.
// - It collects the beats into a line buffer, then presents the line with a one-cycle write strobe.
// - It flags out-of-range refills and memory timeouts as fatal faults.

---
 rtl/i_mem_pkg.sv | 27 ++
 rtl/i_fill_timer.sv | 39 +++
 rtl/i_fill_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/i_mem_pkg.sv
// Shared instruction-memory definitions used by the refill engine and the i-cache.
// Holds the memory window, line geometry, refill FSM encoding and address helpers.
package i_mem_pkg;

    localparam int          LINE_WORDS = 16;
    localparam int          BEAT_W     = $clog2(LINE_WORDS);
    localparam logic [31:0] IMEM_BASE  = 32'h0001_0000;
    localparam logic [31:0] IMEM_LAST  = 32'h0001_01FF;
    localparam int          TIMEOUT    = 255;
    localparam int          TMR_W      = 8;

    typedef enum logic [2:0] {IDLE, REQ, BEAT, WRITE, DRAIN, FAULT} fill_state_t;

    typedef logic [31:0] line_t [0:LINE_WORDS-1];

    function automatic logic [31:0] line_base(input logic [31:0] pc);
        return pc & ~32'(LINE_WORDS - 1);
    endfunction

    // Widened sum so a line near the top of the address space cannot wrap into range.
    function automatic logic line_in_range(input logic [31:0] base);
        logic [32:0] last_word;
        last_word = {1'b0, base} + 33'(LINE_WORDS - 1);
        return (base >= IMEM_BASE) && (last_word <= {1'b0, IMEM_LAST});
    endfunction

endpackage

// File: rtl/i_fill_timer.sv
// Loadable down-counter guarding every wait of the refill engine.
// expired is raised while the count sits at zero.
module i_fill_timer
    import i_mem_pkg::*;
#(
    parameter int WIDTH = TMR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/i_fill_ctrl.sv
// Instruction-cache refill engine: fetches the 16-word line holding a missing PC,
// buffers the beats and hands the line to the i-cache with a one-cycle write strobe.
module i_fill_ctrl
    import i_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        miss,
    input  logic [31:0] miss_pc,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output line_t       fill_ins,
    output logic [31:0] fill_addr,
    output logic        fill_en,
    output logic        busy,
    output logic        fill_fault
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    fill_state_t       state_q, state_d;
    logic [31:0]       base_q, base_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    line_t             line_q, line_d;
    logic              beat_seen;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_expired;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        beat_cnt_d = beat_cnt_q;
        line_d     = line_q;
        beat_seen  = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss && !flush) begin
                    base_d  = line_base(miss_pc);
                    state_d = line_in_range(base_d) ? REQ : FAULT;
                end
            end
            REQ: begin
                // A grant coinciding with flush still has beats in flight; sink them.
                if (flush) begin
                    state_d    = mem_gnt ? DRAIN : IDLE;
                    beat_cnt_d = '0;
                end else if (mem_gnt) begin
                    state_d    = BEAT;
                    beat_cnt_d = '0;
                end else if (tmr_expired) begin
                    state_d = FAULT;
                end
            end
            BEAT: begin
                if (mem_rvalid) begin
                    beat_seen = 1'b1;
                    if (!flush) begin
                        line_d[beat_cnt_q] = mem_rdata;
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = flush ? IDLE : WRITE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        if (flush) begin
                            state_d = DRAIN;
                        end
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end else if (tmr_expired) begin
                    state_d = FAULT;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (mem_rvalid) begin
                    beat_seen = 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end else if (tmr_expired) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // NOTE: the line buffer is reset on purpose: fill_ins must read zero after reset and partial lines are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q <= line_d;
        end
    end

    assign tmr_load = (state_d != state_q) || beat_seen;
    assign tmr_en   = (state_q == REQ) || (state_q == BEAT) || (state_q == DRAIN);

    i_fill_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (TMR_W'(TIMEOUT - 1)),
        .expired  (tmr_expired)
    );

    assign mem_req    = (state_q == REQ);
    assign mem_addr   = mem_req ? base_q : '0;
    assign fill_en    = (state_q == WRITE);
    assign fill_addr  = base_q;
    assign busy       = (state_q != IDLE);
    assign fill_fault = (state_q == FAULT);
    assign fill_ins   = line_q;

endmodule
